// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter
//
// Shares the single OLED SPI word transmitter among N_REQ requesters: the init sequencer
// (index 0), the frame refresh engine and the command/debug port. A requester owns the link
// for a whole burst, which ends with the word flagged REQ_LAST. Each word produces one
// SPI_START pulse, and the SPI_DONE that follows produces one ACK pulse back to its owner.
// A stalled SPI block or an abandoned burst is released after TMO_CYC cycles, signalled by
// ERR_TMO.
//
// Parameters
//   N_REQ    number of requesters (2..8), index 0 is the init sequencer
//   DATA_W   SPI word width, passed through unmodified
//   TMO_CYC  timeout in CLK cycles for SPI_DONE and for the next burst word (>= 2)
//
// Ports
//   CLK        clock
//   RST_N      asynchronous active-low reset
//   REQ        per-requester request, word valid while high
//   REQ_LAST   per-requester flag: current word ends the burst
//   REQ_DATA   per-requester word, requester i at [i*DATA_W +: DATA_W]
//   PRI0       requester 0 wins every idle arbitration it takes part in
//   GNT        one-hot grant, held for the whole burst
//   ACK        one-cycle pulse: word of requester i fully shifted
//   SPI_START  one-cycle start pulse to the SPI block
//   SPI_DATA   word to the SPI block, held until the next issue
//   SPI_DONE   one-cycle pulse from the SPI block, word complete
//   BUSY       high whenever the arbiter is not idle
//   ERR_TMO    one-cycle pulse when a burst is aborted by timeout

module oled_spi_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned TMO_CYC = 4095
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ-1:0]        REQ_LAST,
    input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
    input  logic                    PRI0,
    output logic [N_REQ-1:0]        GNT,
    output logic [N_REQ-1:0]        ACK,
    output logic                    SPI_START,
    output logic [DATA_W-1:0]       SPI_DATA,
    input  logic                    SPI_DONE,
    output logic                    BUSY,
    output logic                    ERR_TMO
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

    // Counter value sampled on the edge where TMO_CYC cycles have elapsed since the
    // counter was cleared.
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(TMO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitDone,
        StWaitNext
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;      // round-robin pointer: first index considered
    logic [IDX_W-1:0] gnt_idx_q;  // index of the requester owning the link
    logic             last_q;     // word in flight ends the burst
    logic [CNT_W-1:0] cnt_q;      // cycles spent waiting for the awaited event

    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic [N_REQ-1:0]  sel_onehot;
    logic [IDX_W-1:0]  next_ptr;
    logic              tmo_hit;

    // ------------------------------------------------------------------------------------
    // Idle arbitration: requester 0 when PRI0 is set and it is requesting, otherwise the
    // first requesting index at or after the pointer, wrapping at N_REQ.
    // ------------------------------------------------------------------------------------
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;

        win_idx  = ptr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (PRI0 && REQ[0]) begin
            win_idx = '0;
            found   = 1'b1;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && REQ[cand_idx]) begin
                win_idx = cand_idx;
                found   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Word to issue: the arbitration winner when idle, the burst owner otherwise. Both
    // issue paths share this mux so they load identical state.
    // ------------------------------------------------------------------------------------
    always_comb begin
        sel_idx             = (state_q == StIdle) ? win_idx : gnt_idx_q;
        sel_data            = REQ_DATA[sel_idx*DATA_W +: DATA_W];
        sel_last            = REQ_LAST[sel_idx];
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
    end

    // The pointer moves past the requester that just released the link, so that
    // requester goes to the back of the queue.
    assign next_ptr = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;
    assign tmo_hit  = (cnt_q == CNT_TC);

    // ------------------------------------------------------------------------------------
    // Controller with registered outputs.
    // ------------------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            GNT       <= '0;
            ACK       <= '0;
            SPI_START <= 1'b0;
            SPI_DATA  <= '0;
            BUSY      <= 1'b0;
            ERR_TMO   <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            SPI_START <= 1'b0;
            ACK       <= '0;
            ERR_TMO   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (|REQ) begin
                        gnt_idx_q <= sel_idx;
                        GNT       <= sel_onehot;
                        SPI_DATA  <= sel_data;
                        last_q    <= sel_last;
                        SPI_START <= 1'b1;
                        cnt_q     <= '0;
                        BUSY      <= 1'b1;
                        state_q   <= StWaitDone;
                    end
                end

                StWaitDone: begin
                    // A done on the terminal-count cycle still completes the word normally.
                    if (SPI_DONE) begin
                        // GNT is the one-hot of the owner, so it doubles as the ACK vector.
                        ACK <= GNT;
                        if (last_q) begin
                            GNT     <= '0;
                            ptr_q   <= next_ptr;
                            BUSY    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StWaitNext;
                        end
                    end else if (tmo_hit) begin
                        ERR_TMO <= 1'b1;
                        GNT     <= '0;
                        ptr_q   <= next_ptr;
                        BUSY    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StWaitNext: begin
                    // While ACK is still high the owner is showing the word just acked, so
                    // its REQ only counts from the following edge on.
                    if (REQ[gnt_idx_q] && !ACK[gnt_idx_q]) begin
                        SPI_DATA  <= sel_data;
                        last_q    <= sel_last;
                        SPI_START <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StWaitDone;
                    end else if (tmo_hit) begin
                        ERR_TMO <= 1'b1;
                        GNT     <= '0;
                        ptr_q   <= next_ptr;
                        BUSY    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    GNT     <= '0;
                    BUSY    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Testbench for oled_spi_arbiter.
//
// One process drives everything from the falling clock edge: a tick samples the DUT
// outputs (scoreboard and invariants), then advances a small SPI block model and the
// requester agents. Expected issues (requester, word) are pushed to a queue when a
// scenario is set up and popped whenever the DUT raises SPI_START.

module tb_oled_spi_arbiter;

    localparam int NR  = 3;
    localparam int DW  = 10;
    localparam int TMO = 24;

    typedef struct packed {
        logic          drop;  // marker: release REQ instead of presenting a word
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } iss_t;

    logic             CLK;
    logic             RST_N;
    logic [NR-1:0]    REQ;
    logic [NR-1:0]    REQ_LAST;
    logic [NR*DW-1:0] REQ_DATA;
    logic             PRI0;
    logic [NR-1:0]    GNT;
    logic [NR-1:0]    ACK;
    logic             SPI_START;
    logic [DW-1:0]    SPI_DATA;
    logic             SPI_DONE;
    logic             BUSY;
    logic             ERR_TMO;

    oled_spi_arbiter #(
        .N_REQ   (NR),
        .DATA_W  (DW),
        .TMO_CYC (TMO)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .REQ_LAST  (REQ_LAST),
        .REQ_DATA  (REQ_DATA),
        .PRI0      (PRI0),
        .GNT       (GNT),
        .ACK       (ACK),
        .SPI_START (SPI_START),
        .SPI_DATA  (SPI_DATA),
        .SPI_DONE  (SPI_DONE),
        .BUSY      (BUSY),
        .ERR_TMO   (ERR_TMO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    n_ack   = 0;
    int    n_err   = 0;
    int    n_start = 0;
    int    ack_cyc = -1000;
    int    err_cyc = -1000;
    int    start_cyc = -1000;
    int    cur_idx = 0;
    int    done_dly = 3;
    int    done_cnt = -1;
    int    pres_cyc [NR];
    logic [NR-1:0] gnt_at_ack;
    word_t wq [NR][$];
    iss_t  exp_q [$];
    int    gap_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        iss_t e;
        check_eq("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
        check_eq("ack_onehot0", 32'($onehot0(ACK)), 32'd1);
        check_eq("ack_err_excl", 32'((|ACK) && ERR_TMO), 32'd0);
        if (SPI_START) begin
            n_start++;
            gap_q.push_back(cyc - ack_cyc);
            start_cyc = cyc;
            check_eq("start_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur_idx = int'(e.idx);
                check_eq("start_gnt", 32'(GNT), 32'(1 << e.idx));
                check_eq("start_data", 32'(SPI_DATA), 32'(e.data));
            end
        end
        if (|ACK) begin
            n_ack++;
            ack_cyc    = cyc;
            gnt_at_ack = GNT;
            check_eq("ack_idx", 32'(ACK), 32'(1 << cur_idx));
        end
        if (ERR_TMO) begin
            n_err++;
            err_cyc = cyc;
        end
    endtask

    // SPI block model: SPI_DONE sampled done_dly+1 edges after the SPI_START edge.
    task automatic slave();
        SPI_DONE = 1'b0;
        if (SPI_START) done_cnt = done_dly;
        else if (done_cnt > 0) done_cnt--;
        else done_cnt = -1;
        if (done_cnt == 0) SPI_DONE = 1'b1;
    endtask

    task automatic present(input int i, input word_t w);
        REQ[i]               = 1'b1;
        REQ_LAST[i]          = w.last;
        REQ_DATA[i*DW +: DW] = w.data;
        pres_cyc[i]          = cyc;
    endtask

    task automatic agents();
        word_t w;
        for (int i = 0; i < NR; i++) begin
            if (REQ[i] && ACK[i]) begin
                REQ[i] = 1'b0;
                if (wq[i].size() > 0) begin
                    w = wq[i].pop_front();
                    if (!w.drop) present(i, w);
                end
            end else if (REQ[i] && ERR_TMO && cur_idx == i) begin
                REQ[i] = 1'b0;
            end else if (!REQ[i] && wq[i].size() > 0) begin
                w = wq[i].pop_front();
                if (!w.drop) present(i, w);
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        monitor();
        slave();
        agents();
    endtask

    function automatic bit idle_now();
        return exp_q.size() == 0 && !BUSY && REQ == '0 && wq[0].size() == 0 &&
               wq[1].size() == 0 && wq[2].size() == 0;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!idle_now() && n < budget);
        check_eq({tag, "_idle"}, 32'(idle_now()), 32'd1);
    endtask

    task automatic run_until_err(input string tag, input int budget);
        int e0 = n_err;
        int n  = 0;
        do begin
            tick();
            n++;
        end while (n_err == e0 && n < budget);
        check_eq({tag, "_err_seen"}, 32'(n_err - e0), 32'd1);
    endtask

    task automatic push_word(input int i, input logic last, input logic [DW-1:0] d,
                             input bit expect_issue);
        word_t w;
        iss_t  e;
        w.drop = 1'b0;
        w.last = last;
        w.data = d;
        wq[i].push_back(w);
        if (expect_issue) begin
            e.idx  = 2'(i);
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_drop(input int i);
        word_t w;
        w.drop = 1'b1;
        w.last = 1'b0;
        w.data = '0;
        wq[i].push_back(w);
    endtask

    task automatic expect_issue(input int i, input logic [DW-1:0] d);
        iss_t e;
        e.idx  = 2'(i);
        e.data = d;
        exp_q.push_back(e);
    endtask

    int a0, e0, s0, n;

    initial begin
        RST_N    = 1'b0;
        REQ      = '0;
        REQ_LAST = '0;
        REQ_DATA = '0;
        PRI0     = 1'b0;
        SPI_DONE = 1'b0;
        for (int i = 0; i < NR; i++) pres_cyc[i] = 0;

        // Reset state.
        repeat (3) tick();
        check_eq("rst_gnt", 32'(GNT), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        tick();
        check_eq("rst_ack", 32'(ACK), 32'd0);
        check_eq("rst_start", 32'(SPI_START), 32'd0);
        check_eq("rst_data", 32'(SPI_DATA), 32'd0);
        check_eq("rst_err", 32'(ERR_TMO), 32'd0);

        // Single word from requester 1, SPI_DONE 20 cycles after start. p -> 2.
        done_dly = 19;
        a0 = n_ack;
        push_word(1, 1'b1, 10'h2AE, 1'b1);
        run_until_idle("single", 200);
        check_eq("single_req_to_start", 32'(start_cyc - pres_cyc[1]), 32'd1);
        check_eq("single_done_to_ack", 32'(ack_cyc - start_cyc), 32'd20);
        check_eq("single_gnt_released", 32'(gnt_at_ack), 32'd0);
        check_eq("single_data_held", 32'(SPI_DATA), 32'h2AE);
        check_eq("single_acks", 32'(n_ack - a0), 32'd1);

        // Pointer at 2: requester 2 beats requester 0. p -> 1.
        done_dly = 3;
        push_word(0, 1'b1, 10'h100, 1'b0);
        push_word(2, 1'b1, 10'h102, 1'b0);
        expect_issue(2, 10'h102);
        expect_issue(0, 10'h100);
        run_until_idle("ptr", 200);

        // Round robin with all requesting from p=1: 1,2,0,1,2,0, each grant one cycle
        // after the previous ACK. p -> 1.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) push_word(i, 1'b1, 10'(12'h110 + 16 * i + r), 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            expect_issue(1, 10'(12'h120 + r));
            expect_issue(2, 10'(12'h130 + r));
            expect_issue(0, 10'(12'h110 + r));
        end
        gap_q.delete();
        run_until_idle("rr", 400);
        check_eq("rr_starts", 32'(gap_q.size()), 32'd6);
        for (int k = 1; k < gap_q.size(); k++) check_eq("rr_gap", 32'(gap_q[k]), 32'd1);

        // PRI0: requester 0 wins every arbitration while requesting. p -> 0.
        PRI0 = 1'b1;
        for (int k = 0; k < 3; k++) push_word(0, 1'b1, 10'(12'h140 + k), 1'b1);
        push_word(1, 1'b1, 10'h150, 1'b1);
        push_word(2, 1'b1, 10'h160, 1'b1);
        run_until_idle("pri0", 400);
        PRI0 = 1'b0;

        // Burst lock: 4-word burst from requester 2 while requester 0 waits. p -> 1.
        for (int k = 0; k < 4; k++) push_word(2, k == 3, 10'(12'h0A0 + k), 1'b1);
        gap_q.delete();
        tick();
        push_word(0, 1'b1, 10'h1F0, 1'b1);
        run_until_idle("burst", 400);
        check_eq("burst_starts", 32'(gap_q.size()), 32'd5);
        if (gap_q.size() == 5) begin
            for (int k = 1; k < 4; k++) check_eq("burst_intra_gap", 32'(gap_q[k]), 32'd2);
            check_eq("burst_handover_gap", 32'(gap_q[4]), 32'd1);
        end

        // Done timeout: requester 1 never completes, requester 2 served next. p -> 0.
        done_dly = -1;
        a0 = n_ack;
        e0 = n_err;
        push_word(1, 1'b1, 10'h155, 1'b1);
        push_word(2, 1'b1, 10'h166, 1'b1);
        run_until_err("dtmo", 200);
        check_eq("dtmo_delay", 32'(err_cyc - start_cyc), 32'(TMO));
        check_eq("dtmo_busy", 32'(BUSY), 32'd0);
        check_eq("dtmo_gnt", 32'(GNT), 32'd0);
        check_eq("dtmo_no_ack", 32'(n_ack - a0), 32'd0);
        done_dly = 3;
        run_until_idle("dtmo_next", 200);
        check_eq("dtmo_acks", 32'(n_ack - a0), 32'd1);
        check_eq("dtmo_errs", 32'(n_err - e0), 32'd1);

        // Burst abandon: requester 1 drops REQ after a non-last ACK. p -> 2.
        a0 = n_ack;
        e0 = n_err;
        push_word(1, 1'b0, 10'h1A0, 1'b1);
        push_drop(1);
        run_until_idle("abandon", 200);
        check_eq("abandon_delay", 32'(err_cyc - ack_cyc), 32'(TMO));
        check_eq("abandon_acks", 32'(n_ack - a0), 32'd1);
        check_eq("abandon_errs", 32'(n_err - e0), 32'd1);

        // SPI_DONE on the terminal-count cycle: normal ACK, no timeout. p -> 1.
        done_dly = TMO - 1;
        a0 = n_ack;
        e0 = n_err;
        push_word(0, 1'b1, 10'h1C0, 1'b1);
        run_until_idle("tc_done", 200);
        check_eq("tc_done_delay", 32'(ack_cyc - start_cyc), 32'(TMO));
        check_eq("tc_done_acks", 32'(n_ack - a0), 32'd1);
        check_eq("tc_done_errs", 32'(n_err - e0), 32'd0);

        // Asynchronous reset while waiting for SPI_DONE.
        done_dly = -1;
        s0 = n_start;
        push_word(2, 1'b1, 10'h1E0, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (n_start == s0 && n < 50);
        check_eq("rstmid_started", 32'(n_start - s0), 32'd1);
        repeat (3) tick();
        check_eq("rstmid_busy_before", 32'(BUSY), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check_eq("rstmid_gnt", 32'(GNT), 32'd0);
        check_eq("rstmid_ack", 32'(ACK), 32'd0);
        check_eq("rstmid_start", 32'(SPI_START), 32'd0);
        check_eq("rstmid_data", 32'(SPI_DATA), 32'd0);
        check_eq("rstmid_busy", 32'(BUSY), 32'd0);
        check_eq("rstmid_err", 32'(ERR_TMO), 32'd0);
        REQ = '0;
        for (int i = 0; i < NR; i++) wq[i].delete();
        exp_q.delete();
        done_cnt = -1;
        repeat (2) tick();
        RST_N = 1'b1;

        // Pointer restarts at 0: requester 0 before requester 1.
        done_dly = 3;
        push_word(0, 1'b1, 10'h1E2, 1'b1);
        push_word(1, 1'b1, 10'h1E3, 1'b1);
        run_until_idle("post_rst", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
